// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: resolves hazards by priority,
// tracks the multi-cycle divider, holds un-accepted fetch redirects and counts stall cycles.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_is_load,
    input  logic             e_is_div,
    input  logic             e_mispredict,
    input  logic             m_exception,
    input  logic             f_mem_busy,
    input  logic             m_mem_busy,
    input  logic             div_done,
    input  logic             redirect_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             flush_w,
    output logic             div_start,
    output logic             div_kill,
    output logic             redirect_valid,
    output logic             redirect_cause,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    typedef enum logic {ST_RUN, ST_DIV_WAIT} state_t;

    state_t           r_state;
    logic             r_rp;
    logic             r_rp_cause;
    logic [CNT_W-1:0] r_cnt;

    logic w_exc;
    logic w_load_use;
    logic w_in_div;
    logic w_launch;
    logic w_req;
    logic w_req_cause;

    assign w_exc      = m_exception & ~m_mem_busy;
    assign w_in_div   = (r_state == ST_DIV_WAIT);
    assign w_load_use = e_is_load & (e_rd != 5'd0) &
                        ((d_use_rs1 & (d_rs1 == e_rd)) | (d_use_rs2 & (d_rs2 == e_rd)));
    assign w_launch   = ~w_exc & ~m_mem_busy & ~w_in_div & e_is_div;

    // Only the highest-priority condition drives stalls; a pending redirect adds flush_d on top.
    always_comb begin
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        flush_m        = 1'b0;
        flush_w        = 1'b0;
        div_start      = 1'b0;
        div_kill       = 1'b0;
        redirect_valid = 1'b0;
        redirect_cause = 1'b0;
        w_req          = 1'b0;
        w_req_cause    = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            if (w_exc) begin
                flush_d     = 1'b1;
                flush_e     = 1'b1;
                flush_m     = 1'b1;
                flush_w     = 1'b1;
                w_req       = 1'b1;
                w_req_cause = 1'b1;
                div_kill    = w_in_div;
            end else if (m_mem_busy) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (w_in_div) begin
                // On the div_done cycle nothing is stalled so the result leaves E.
                if (!div_done) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    flush_m = 1'b1;
                end
            end else if (e_is_div) begin
                div_start = 1'b1;
                stall_f   = 1'b1;
                stall_d   = 1'b1;
                stall_e   = 1'b1;
                flush_m   = 1'b1;
            end else if (e_mispredict) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                w_req   = 1'b1;
            end else if (w_load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (f_mem_busy) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end

            if (r_rp) begin
                flush_d = 1'b1;
            end
            redirect_valid = w_req | r_rp;
            redirect_cause = w_req ? w_req_cause : r_rp_cause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_rp       <= 1'b0;
            r_rp_cause <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_RUN:      if (w_launch) r_state <= ST_DIV_WAIT;
                ST_DIV_WAIT: if (w_exc || (!m_mem_busy && div_done)) r_state <= ST_RUN;
                default:     r_state <= ST_RUN;
            endcase

            // A fresh request refreshes the latched cause, so an exception overrides a pending branch.
            if (redirect_valid && redirect_ready) begin
                r_rp <= 1'b0;
            end else if (w_req) begin
                r_rp       <= 1'b1;
                r_rp_cause <= w_req_cause;
            end

            if (stall_d && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt = r_cnt;

endmodule
